chan_mux_seq: RTL and testbench

- Parametrised, registered N:1 channel multiplexer.
- Generalises the 4-input, 1-bit combinational mux: NUM_CH channels, each WIDTH bits wide.
- Two modes: direct (one sample of a selected channel) and scan (one sample of every channel, in order).
- Output uses a valid/ready handshake. Sits between parallel sample sources and a single serial consumer.

---
 rtl/chan_mux_pkg.sv | 17 +
 rtl/chan_select.sv | 28 ++
 rtl/chan_mux_seq.sv | 166 ++++++++++++++++
 tb/tb_chan_mux_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg
//   Shared types and constants for the channel multiplexer family.
//   - state_t     : controller state encoding (IDLE / DIRECT / SCAN)
//   - MODE_DIRECT : mode value for a single sample of the selected channel
//   - MODE_SCAN   : mode value for one sample of every channel, in order
package chan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_select.sv
// chan_select
//   Purely combinational N:1 slice selector over a packed channel bus.
//   Ports:
//     in_data [NUM_CH*WIDTH] : packed channels, channel k at [k*WIDTH +: WIDTH]
//     index   [SEL_W]        : channel to pick
//     word    [WIDTH]        : selected channel; zero if index >= NUM_CH
module chan_select #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        index,
  output logic [WIDTH-1:0]        word
);

  // Compare against every legal index rather than multiplying the index,
  // so out-of-range indices (non power-of-two NUM_CH) simply yield zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (index == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq
//   Registered NUM_CH:1 channel multiplexer with direct and scan modes and a
//   valid/ready output handshake.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     in_data           : packed channel samples
//     sel, mode, start  : transaction request, sampled only when accepted in IDLE
//     abort             : synchronous cancel, beats start and the handshake
//     out_data, out_ch  : registered sample and its channel index
//     out_valid/ready   : output handshake
//     busy              : high while a transaction is in progress
//     sel_err           : one-cycle pulse for a direct start with sel >= NUM_CH
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    abort,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              sel_err_q, sel_err_d;

  logic              handshake;
  logic              sel_oob;
  logic              load;
  logic [SEL_W-1:0]  load_idx;
  logic [WIDTH-1:0]  load_word;

  assign handshake = out_valid_q && out_ready;
  // Zero-extend so the compare works when NUM_CH is a power of two.
  assign sel_oob   = ({1'b0, sel} >= NUM_CH_W);

  chan_select #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .SEL_W  (SEL_W)
  ) u_select (
    .in_data (in_data),
    .index   (load_idx),
    .word    (load_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (mode == MODE_SCAN) begin
              state_d = SCAN;
            end else if (!sel_oob) begin
              state_d = DIRECT;
            end
          end
        end
        DIRECT: begin
          if (handshake) state_d = IDLE;
        end
        SCAN: begin
          if (handshake && (out_ch_q == LAST_CH)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath logic. Everything holds unless a load or a
  // completing handshake happens; abort only clears out_valid.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = 1'b0;
    load        = 1'b0;
    load_idx    = '0;
    if (abort) begin
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (mode == MODE_SCAN) begin
              load     = 1'b1;
              load_idx = '0;
            end else if (sel_oob) begin
              sel_err_d = 1'b1;
            end else begin
              load     = 1'b1;
              load_idx = sel;
            end
          end
        end
        DIRECT: begin
          if (handshake) out_valid_d = 1'b0;
        end
        SCAN: begin
          if (handshake) begin
            if (out_ch_q == LAST_CH) begin
              out_valid_d = 1'b0;
            end else begin
              load     = 1'b1;
              load_idx = out_ch_q + SEL_W'(1);
            end
          end
        end
        default: out_valid_d = 1'b0;
      endcase
    end
    if (load) begin
      out_data_d  = load_word;
      out_ch_d    = load_idx;
      out_valid_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// tb_chan_mux_seq
//   Directed bench for chan_mux_seq: a 4-channel instance for the main
//   scenarios and a 3-channel instance for the out-of-range select case.
module tb_chan_mux_seq;

  logic        clk;
  logic        rst_n;

  // 4-channel instance
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        mode, start, abort, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid, busy, sel_err;

  // 3-channel instance
  logic [23:0] in_data3;
  logic [1:0]  sel3;
  logic        mode3, start3, abort3, out_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3, busy3, sel_err3;

  int total;
  int bad;

  logic [7:0] exp_scan [4];

  chan_mux_seq #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .start     (start),
    .abort     (abort),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .sel_err   (sel_err)
  );

  chan_mux_seq #(.NUM_CH(3), .WIDTH(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .sel       (sel3),
    .mode      (mode3),
    .start     (start3),
    .abort     (abort3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .busy      (busy3),
    .sel_err   (sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (out_data !== 8'h00 || out_ch !== 2'd0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || sel_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got data=%h ch=%0d v=%b busy=%b err=%b required all zero",
               out_data, out_ch, out_valid, busy, sel_err);
    end
    total++;
    if (out_valid3 !== 1'b0 || busy3 !== 1'b0 || sel_err3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs3 got v=%b busy=%b err=%b required 0 0 0",
               out_valid3, busy3, sel_err3);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_direct();
    mode = 1'b0; sel = 2'd2; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_ch !== 2'd2 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL direct_beat got v=%b data=%h ch=%0d busy=%b required 1 c2 2 1",
               out_valid, out_data, out_ch, busy);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL direct_done got v=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_scan();
    mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_scan[i] || out_ch !== 2'(i)) begin
        bad++;
        $display("[TB] FAIL scan_beat%0d got v=%b data=%h ch=%0d required 1 %h %0d",
                 i, out_valid, out_data, out_ch, exp_scan[i], i);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL scan_done got v=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (out_data !== 8'hA0 || out_ch !== 2'd0) begin
      bad++;
      $display("[TB] FAIL bp_ch0 got data=%h ch=%0d required a0 0", out_data, out_ch);
    end
    step();
    out_ready = 1'b0;
    in_data[15:8] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_ch !== 2'd1 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_stall%0d got v=%b data=%h ch=%0d busy=%b required 1 b1 1 1",
                 i, out_valid, out_data, out_ch, busy);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_ch !== 2'd2) begin
      bad++;
      $display("[TB] FAIL bp_resume_ch2 got v=%b data=%h ch=%0d required 1 c2 2",
               out_valid, out_data, out_ch);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hD3 || out_ch !== 2'd3) begin
      bad++;
      $display("[TB] FAIL bp_resume_ch3 got v=%b data=%h ch=%0d required 1 d3 3",
               out_valid, out_data, out_ch);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_done got v=%b busy=%b required 0 0", out_valid, busy);
    end
    in_data[15:8] = 8'hB1;
  endtask

  task automatic test_abort();
    mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    // start while busy must be ignored
    start = 1'b1; mode = 1'b0; sel = 2'd0;
    step();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hC2) begin
      bad++;
      $display("[TB] FAIL abort_pre got v=%b data=%h ch=%0d required 1 c2 2",
               out_valid, out_data, out_ch);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'hC2 || out_ch !== 2'd2) begin
      bad++;
      $display("[TB] FAIL abort_clear got v=%b busy=%b data=%h ch=%0d required 0 0 c2 2",
               out_valid, busy, out_data, out_ch);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL abort_quiet%0d got v=%b busy=%b required 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    // start held high: refused on the completion edge, accepted one later
    mode = 1'b0; sel = 2'd1; start = 1'b1; out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_ch !== 2'd1) begin
      bad++;
      $display("[TB] FAIL b2b_first got v=%b data=%h ch=%0d required 1 b1 1",
               out_valid, out_data, out_ch);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_gap got v=%b busy=%b required 0 0", out_valid, busy);
    end
    step();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_second got v=%b ch=%0d busy=%b required 1 1 1",
               out_valid, out_ch, busy);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_done got v=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_sel_err();
    mode3 = 1'b0; sel3 = 2'd3; start3 = 1'b1; out_ready3 = 1'b1;
    step();
    start3 = 1'b0;
    total++;
    if (sel_err3 !== 1'b1 || out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL selerr_pulse got err=%b v=%b busy=%b required 1 0 0",
               sel_err3, out_valid3, busy3);
    end
    step();
    total++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL selerr_end got err=%b v=%b busy=%b required 0 0 0",
               sel_err3, out_valid3, busy3);
    end
    // last legal channel of the 3-channel instance
    sel3 = 2'd2; start3 = 1'b1;
    step();
    start3 = 1'b0;
    total++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'hC2 || out_ch3 !== 2'd2 || sel_err3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL selerr_last got v=%b data=%h ch=%0d err=%b required 1 c2 2 0",
               out_valid3, out_data3, out_ch3, sel_err3);
    end
    step();
  endtask

  task automatic test_async_reset();
    mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_data !== 8'h00 || out_ch !== 2'd0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || sel_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset got data=%h ch=%0d v=%b busy=%b err=%b required all zero",
               out_data, out_ch, out_valid, busy, sel_err);
    end
    step();
    rst_n = 1'b1;
    step();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      bad++;
      $display("[TB] FAIL reset_rescan got v=%b data=%h ch=%0d required 1 a0 0",
               out_valid, out_data, out_ch);
    end
    step();
    total++;
    if (out_ch !== 2'd1 || out_data !== 8'hB1) begin
      bad++;
      $display("[TB] FAIL reset_rescan1 got data=%h ch=%0d required b1 1", out_data, out_ch);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_scan[0] = 8'hA0;
    exp_scan[1] = 8'hB1;
    exp_scan[2] = 8'hC2;
    exp_scan[3] = 8'hD3;
    in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_data3 = {8'hC2, 8'hB1, 8'hA0};
    sel = 2'd0; mode = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    sel3 = 2'd0; mode3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b1;
    rst_n = 1'b1;
    #2;

    test_reset();
    test_direct();
    test_scan();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_sel_err();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
